shift_reg: RTL and testbench



---
 rtl/shift_reg.sv | 67 ++++++
 tb/tb_shift_reg.sv | 111 +++++++++++
 2 files changed

// File: rtl/shift_reg.sv
// Walking-LED shift register: one lit bit moves across cnt at a prescaled rate.
// It either rotates with wrap or bounces between the end bits, and recovers from a non-one-hot state.
module shift_reg #(
    parameter int CNT_SIZE  = 4,
    parameter int SHIFT_DIV = 1,
    parameter int BOUNCE    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [CNT_SIZE-1:0] cnt
);

    localparam int                PW         = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(SHIFT_DIV - 1);
    localparam logic [CNT_SIZE-1:0] CNT_INIT = {{(CNT_SIZE-1){1'b0}}, 1'b1};

    typedef enum logic {
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    logic [PW-1:0]       presc, presc_next;
    logic                tick;
    dir_t                dir, dir_next;
    logic [CNT_SIZE-1:0] cnt_next, shl, shr;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        tick       = (presc == PRESC_LAST);
        presc_next = tick ? '0 : presc + PW'(1);
        shl        = {cnt[CNT_SIZE-2:0], cnt[CNT_SIZE-1]};
        shr        = {cnt[0], cnt[CNT_SIZE-1:1]};
        cnt_next   = cnt;
        dir_next   = dir;

        if (tick) begin
            // A corrupted pattern restarts from the LSB, moving left.
            if (!$onehot(cnt)) begin
                cnt_next = CNT_INIT;
                dir_next = DIR_LEFT;
            end else if (BOUNCE == 0) begin
                cnt_next = shl;
            end else if (dir == DIR_LEFT) begin
                cnt_next = shl;
                if (shl[CNT_SIZE-1]) dir_next = DIR_RIGHT;
            end else begin
                cnt_next = shr;
                if (shr[0]) dir_next = DIR_LEFT;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    // rst_n is active-high here: 1 holds the block in reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt   <= CNT_INIT;
            presc <= '0;
            dir   <= DIR_LEFT;
        end else begin
            cnt   <= cnt_next;
            presc <= presc_next;
            dir   <= dir_next;
        end
    end

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg with three instances: rotate, prescaled rotate and bounce.
// Expected patterns are queued as each edge is driven and compared on the following falling edge.
module tb_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] cnt_a, cnt_b, cnt_c;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] q_a[$];
    logic [3:0] q_b[$];
    logic [3:0] q_c[$];

    // Reference model state
    int pos_a, pos_b, pre_b, ph_c;
    logic [3:0] bounce_tab [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};

    logic onehot_en = 1'b0;
    logic onehot_skip = 1'b0;
    int   n_cycle = 0;

    always #20 clk = ~clk;

    shift_reg #(.CNT_SIZE(4), .SHIFT_DIV(1), .BOUNCE(0)) dut_a (.clk(clk), .rst_n(rst_n), .cnt(cnt_a));
    shift_reg #(.CNT_SIZE(4), .SHIFT_DIV(3), .BOUNCE(0)) dut_b (.clk(clk), .rst_n(rst_n), .cnt(cnt_b));
    shift_reg #(.CNT_SIZE(4), .SHIFT_DIV(1), .BOUNCE(1)) dut_c (.clk(clk), .rst_n(rst_n), .cnt(cnt_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge: drive reset, push model expectations, then compare on the next falling edge.
    task automatic cycle(input logic rst, input logic recover);
        logic [3:0] exp_a, exp_b, exp_c;
        rst_n = rst;
        if (rst) begin
            pos_a = 0; pos_b = 0; pre_b = 0; ph_c = 0;
        end else begin
            pos_a = recover ? 0 : (pos_a + 1) % 4;
            ph_c  = recover ? 0 : (ph_c + 1) % 6;
            if (pre_b == 2) begin
                pre_b = 0;
                pos_b = (pos_b + 1) % 4;
            end else begin
                pre_b++;
            end
        end
        q_a.push_back(4'b0001 << pos_a);
        q_b.push_back(4'b0001 << pos_b);
        q_c.push_back(bounce_tab[ph_c]);

        @(posedge clk);
        @(negedge clk);
        n_cycle++;
        if (q_a.size() == 0 || q_b.size() == 0 || q_c.size() == 0) begin
            check($sformatf("queue_empty[%0d]", n_cycle), 32'd0, 32'd1);
        end else begin
            exp_a = q_a.pop_front();
            exp_b = q_b.pop_front();
            exp_c = q_c.pop_front();
            check($sformatf("rotate[%0d]", n_cycle), 32'(cnt_a), 32'(exp_a));
            check($sformatf("presc[%0d]", n_cycle), 32'(cnt_b), 32'(exp_b));
            check($sformatf("bounce[%0d]", n_cycle), 32'(cnt_c), 32'(exp_c));
        end
    endtask

    always @(negedge clk) begin
        if (onehot_en && !onehot_skip) begin
            check("onehot_a", 32'($onehot(cnt_a)), 32'd1);
            check("onehot_b", 32'($onehot(cnt_b)), 32'd1);
            check("onehot_c", 32'($onehot(cnt_c)), 32'd1);
        end
    end

    initial begin
        @(negedge clk);
        // Reset held for two edges
        cycle(1'b1, 1'b0);
        onehot_en = 1'b1;
        cycle(1'b1, 1'b0);

        // Free run: rotate wrap, prescaler every 3rd edge, full bounce period
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0);

        // Mid-run reset with the prescaled instance at 0100 mid-count
        check("b_before_reset", 32'(cnt_b), 32'h4);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

        // Corrupt the pattern in the single-rate instances and expect recovery on the next tick
        onehot_skip = 1'b1;
        force dut_a.cnt = 4'b0110;
        force dut_c.cnt = 4'b0110;
        #1;
        release dut_a.cnt;
        release dut_c.cnt;
        cycle(1'b0, 1'b1);
        onehot_skip = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
